// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MEM pipeline stage. Accepts one instruction from EX over a
//                give/get handshake, performs the load or store on the data
//                memory bus, then offers the instruction and its result to WB
//                over a second give/get handshake. One instruction in flight.
//
//  Ports
//    clk                   clock, all state on the rising edge
//    rst_i                 synchronous reset, active-high
//    EX_MEM_give_i         EX offers an instruction
//    MEM_EX_get_o          MEM can accept from EX
//    EX_MEM_instruction_i  instruction word
//    EX_MEM_result_i       ALU result / effective address
//    EX_MEM_rs2_i          store data
//    dmem_req_o            memory request valid
//    dmem_we_o             1 = store, 0 = load
//    dmem_addr_o           word-aligned address
//    dmem_wdata_o          store data, lane-replicated
//    dmem_be_o             byte enables (all ones on loads)
//    dmem_ack_i            request completed; rdata valid in the same cycle
//    dmem_rdata_i          load data word
//    WB_MEM_get_i          WB can accept
//    MEM_WB_give_o         MEM offers a result
//    MEM_WB_instruction_o  instruction to WB
//    MEM_WB_result_o       load data or passed-through result
//    misaligned_o          offered instruction was a misaligned access
//
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage #(
    parameter int BITSIZE = 32
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               EX_MEM_give_i,
    output logic               MEM_EX_get_o,
    input  logic [31:0]        EX_MEM_instruction_i,
    input  logic [BITSIZE-1:0] EX_MEM_result_i,
    input  logic [BITSIZE-1:0] EX_MEM_rs2_i,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    output logic [31:0]        dmem_addr_o,
    output logic [31:0]        dmem_wdata_o,
    output logic [3:0]         dmem_be_o,
    input  logic               dmem_ack_i,
    input  logic [31:0]        dmem_rdata_i,
    input  logic               WB_MEM_get_i,
    output logic               MEM_WB_give_o,
    output logic [31:0]        MEM_WB_instruction_o,
    output logic [BITSIZE-1:0] MEM_WB_result_o,
    output logic               misaligned_o
);

    localparam logic [6:0] c_OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE = 7'b0100011;

    // Access size encoding
    localparam logic [1:0] c_SZ_BYTE = 2'd0;
    localparam logic [1:0] c_SZ_HALF = 2'd1;
    localparam logic [1:0] c_SZ_WORD = 2'd2;

    localparam logic [1:0] S_GET_INSTR   = 2'd0;
    localparam logic [1:0] S_MEM_ACCESS  = 2'd1;
    localparam logic [1:0] S_GIVE_RESULT = 2'd2;

    // Loads and stores decode funct3 differently: LBU/LHU (100/101) are
    // narrow loads, whereas any store funct3 other than SB/SH is a word.
    function automatic logic [1:0] f_size(input logic is_load, input logic [2:0] f3);
        logic [1:0] sz;
        sz = c_SZ_WORD;
        if (is_load) begin
            case (f3)
                3'b000, 3'b100: sz = c_SZ_BYTE;
                3'b001, 3'b101: sz = c_SZ_HALF;
                default:        sz = c_SZ_WORD;
            endcase
        end else begin
            case (f3)
                3'b000:  sz = c_SZ_BYTE;
                3'b001:  sz = c_SZ_HALF;
                default: sz = c_SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [31:0]        r_instr;
    logic [BITSIZE-1:0] r_result;
    logic [BITSIZE-1:0] r_rs2;
    logic               r_misaligned;

    // ------------------------------------------------------------------
    // Decode of the instruction being offered by EX
    // ------------------------------------------------------------------
    logic       w_in_load;
    logic       w_in_store;
    logic [1:0] w_in_size;
    logic       w_in_mis;
    logic       w_in_mem_ok;

    always_comb begin
        w_in_load  = (EX_MEM_instruction_i[6:0] == c_OPC_LOAD);
        w_in_store = (EX_MEM_instruction_i[6:0] == c_OPC_STORE);
        w_in_size  = f_size(w_in_load, EX_MEM_instruction_i[14:12]);
        w_in_mis   = 1'b0;
        if (w_in_load || w_in_store) begin
            if (w_in_size == c_SZ_HALF)
                w_in_mis = EX_MEM_result_i[0];
            else if (w_in_size == c_SZ_WORD)
                w_in_mis = |EX_MEM_result_i[1:0];
        end
        w_in_mem_ok = (w_in_load || w_in_store) && !w_in_mis;
    end

    // ------------------------------------------------------------------
    // Decode of the latched instruction
    // ------------------------------------------------------------------
    logic       w_is_load;
    logic       w_is_store;
    logic [1:0] w_size;
    logic [1:0] w_lane;
    logic       w_signed;

    always_comb begin
        w_is_load  = (r_instr[6:0] == c_OPC_LOAD);
        w_is_store = (r_instr[6:0] == c_OPC_STORE);
        w_size     = f_size(w_is_load, r_instr[14:12]);
        w_lane     = r_result[1:0];
        w_signed   = ~r_instr[14];
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_i)
            r_state <= S_GET_INSTR;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_GET_INSTR:
                if (EX_MEM_give_i)
                    w_next_state = w_in_mem_ok ? S_MEM_ACCESS : S_GIVE_RESULT;
            S_MEM_ACCESS:
                if (dmem_ack_i)
                    w_next_state = S_GIVE_RESULT;
            S_GIVE_RESULT:
                if (WB_MEM_get_i)
                    w_next_state = S_GET_INSTR;
            default:
                w_next_state = S_GET_INSTR;
        endcase
    end

    // ------------------------------------------------------------------
    // Load data lane extraction and extension
    // ------------------------------------------------------------------
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [BITSIZE-1:0] w_load_data;

    always_comb begin
        case (w_lane)
            2'd0:    w_byte = dmem_rdata_i[7:0];
            2'd1:    w_byte = dmem_rdata_i[15:8];
            2'd2:    w_byte = dmem_rdata_i[23:16];
            default: w_byte = dmem_rdata_i[31:24];
        endcase
        w_half = w_lane[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (w_size)
            c_SZ_BYTE: w_load_data = {{24{w_signed & w_byte[7]}}, w_byte};
            c_SZ_HALF: w_load_data = {{16{w_signed & w_half[15]}}, w_half};
            default:   w_load_data = dmem_rdata_i;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_instr      <= '0;
            r_result     <= '0;
            r_rs2        <= '0;
            r_misaligned <= 1'b0;
        end else begin
            if (r_state == S_GET_INSTR && EX_MEM_give_i) begin
                r_instr      <= EX_MEM_instruction_i;
                r_result     <= EX_MEM_result_i;
                r_rs2        <= EX_MEM_rs2_i;
                r_misaligned <= w_in_mis;
            end
            // A store keeps its address as the result.
            if (r_state == S_MEM_ACCESS && dmem_ack_i && w_is_load)
                r_result <= w_load_data;
        end
    end

    // ------------------------------------------------------------------
    // Memory bus: only driven while the request is outstanding, which
    // keeps every field stable from first request cycle to ack.
    // ------------------------------------------------------------------
    logic w_in_mem;
    assign w_in_mem = (r_state == S_MEM_ACCESS);

    always_comb begin
        dmem_req_o   = w_in_mem;
        dmem_we_o    = w_in_mem & w_is_store;
        dmem_addr_o  = w_in_mem ? {r_result[31:2], 2'b00} : 32'd0;
        dmem_be_o    = 4'b0000;
        dmem_wdata_o = 32'd0;
        if (w_in_mem) begin
            if (w_is_store) begin
                case (w_size)
                    c_SZ_BYTE: begin
                        dmem_be_o    = 4'b0001 << w_lane;
                        dmem_wdata_o = {4{r_rs2[7:0]}};
                    end
                    c_SZ_HALF: begin
                        dmem_be_o    = w_lane[1] ? 4'b1100 : 4'b0011;
                        dmem_wdata_o = {2{r_rs2[15:0]}};
                    end
                    default: begin
                        dmem_be_o    = 4'b1111;
                        dmem_wdata_o = r_rs2;
                    end
                endcase
            end else begin
                dmem_be_o = 4'b1111;
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake outputs. get is masked during reset so that every output
    // reads 0 while rst_i is held.
    // ------------------------------------------------------------------
    assign MEM_EX_get_o         = (r_state == S_GET_INSTR) & ~rst_i;
    assign MEM_WB_give_o        = (r_state == S_GIVE_RESULT);
    assign MEM_WB_instruction_o = r_instr;
    assign MEM_WB_result_o      = r_result;
    assign misaligned_o         = (r_state == S_GIVE_RESULT) & r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage. Directed vector table,
//                randomized vectors scored against a behavioural model, and
//                hand-written reset / stall sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        EX_MEM_give_i;
    logic        MEM_EX_get_o;
    logic [31:0] EX_MEM_instruction_i;
    logic [31:0] EX_MEM_result_i;
    logic [31:0] EX_MEM_rs2_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        WB_MEM_get_i;
    logic        MEM_WB_give_o;
    logic [31:0] MEM_WB_instruction_o;
    logic [31:0] MEM_WB_result_o;
    logic        misaligned_o;

    always #5 clk = ~clk;

    mem_stage #(.BITSIZE(32)) dut (
        .clk                  (clk),
        .rst_i                (rst_i),
        .EX_MEM_give_i        (EX_MEM_give_i),
        .MEM_EX_get_o         (MEM_EX_get_o),
        .EX_MEM_instruction_i (EX_MEM_instruction_i),
        .EX_MEM_result_i      (EX_MEM_result_i),
        .EX_MEM_rs2_i         (EX_MEM_rs2_i),
        .dmem_req_o           (dmem_req_o),
        .dmem_we_o            (dmem_we_o),
        .dmem_addr_o          (dmem_addr_o),
        .dmem_wdata_o         (dmem_wdata_o),
        .dmem_be_o            (dmem_be_o),
        .dmem_ack_i           (dmem_ack_i),
        .dmem_rdata_i         (dmem_rdata_i),
        .WB_MEM_get_i         (WB_MEM_get_i),
        .MEM_WB_give_o        (MEM_WB_give_o),
        .MEM_WB_instruction_o (MEM_WB_instruction_o),
        .MEM_WB_result_o      (MEM_WB_result_o),
        .misaligned_o         (misaligned_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] result;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          ack_wait;
        int          get_wait;
        logic        exp_req;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_res;
        logic        exp_mis;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural reference: works from byte counts and arithmetic only.
    function automatic void model(inout vec_t v);
        logic [6:0]  opc;
        int unsigned f3, nbytes, off;
        logic        ld, st;
        logic [63:0] mask, val;
        opc    = v.instr[6:0];
        f3     = v.instr[14:12];
        ld     = (opc == 7'b0000011);
        st     = (opc == 7'b0100011);
        if (ld) nbytes = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
        else    nbytes = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
        off    = v.result % 4;
        v.exp_mis = (ld || st) && ((v.result % nbytes) != 0);
        v.exp_req = (ld || st) && !v.exp_mis;
        v.exp_we  = st;
        mask      = (64'd1 << (8 * nbytes)) - 1;
        v.exp_be  = st ? 4'(((1 << nbytes) - 1) << off) : 4'hF;
        if (nbytes == 1)      v.exp_wdata = (v.rs2 & 32'hFF) * 32'h01010101;
        else if (nbytes == 2) v.exp_wdata = (v.rs2 & 32'hFFFF) * 32'h00010001;
        else                  v.exp_wdata = v.rs2;
        v.exp_res = v.result;
        if (v.exp_req && ld) begin
            val = (64'(v.rdata) >> (8 * off)) & mask;
            if ((f3 == 0 || f3 == 1) && val[8*nbytes-1])
                val = val | ~mask;
            v.exp_res = val[31:0];
        end
    endfunction

    // Drive one instruction through the stage and check every phase.
    task automatic run_vec(input vec_t v, input string tag);
        int          t;
        int          lat;
        int          reqc;
        bit          done;
        logic [31:0] held_res;
        t = 0;
        @(negedge clk);
        while (!MEM_EX_get_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " get_o_ready"}, {31'd0, MEM_EX_get_o}, 32'd1);
        EX_MEM_give_i        = 1'b1;
        EX_MEM_instruction_i = v.instr;
        EX_MEM_result_i      = v.result;
        EX_MEM_rs2_i         = v.rs2;
        @(posedge clk);
        #1;
        EX_MEM_give_i        = 1'b0;
        EX_MEM_instruction_i = $urandom();
        EX_MEM_result_i      = $urandom();
        EX_MEM_rs2_i         = $urandom();
        lat  = 0;
        reqc = 0;
        done = 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
            dmem_ack_i = 1'b0;
            if (MEM_WB_give_o) begin
                done = 1;
            end else if (dmem_req_o) begin
                reqc++;
                chk({tag, " addr"}, dmem_addr_o, {v.result[31:2], 2'b00});
                chk({tag, " we"}, {31'd0, dmem_we_o}, {31'd0, v.exp_we});
                chk({tag, " be"}, {28'd0, dmem_be_o}, {28'd0, v.exp_be});
                if (v.exp_we) chk({tag, " wdata"}, dmem_wdata_o, v.exp_wdata);
                chk({tag, " get_o_busy"}, {31'd0, MEM_EX_get_o}, 32'd0);
                if (reqc == v.ack_wait + 1) begin
                    dmem_ack_i   = 1'b1;
                    dmem_rdata_i = v.rdata;
                end
            end
        end
        chk({tag, " give_timeout"}, {31'd0, done}, 32'd1);
        chk({tag, " req_cycles"}, reqc, v.exp_req ? v.ack_wait + 1 : 0);
        chk({tag, " latency"}, lat, v.exp_req ? v.ack_wait + 2 : 1);
        chk({tag, " result"}, MEM_WB_result_o, v.exp_res);
        chk({tag, " instr"}, MEM_WB_instruction_o, v.instr);
        chk({tag, " misaligned"}, {31'd0, misaligned_o}, {31'd0, v.exp_mis});
        held_res = MEM_WB_result_o;
        // WB stalls; a spurious ack must not disturb the offered result.
        for (int i = 0; i < v.get_wait; i++) begin
            dmem_ack_i   = 1'b1;
            dmem_rdata_i = $urandom();
            @(negedge clk);
            chk({tag, " stall_give"}, {31'd0, MEM_WB_give_o}, 32'd1);
            chk({tag, " stall_result"}, MEM_WB_result_o, held_res);
            chk({tag, " stall_get_o"}, {31'd0, MEM_EX_get_o}, 32'd0);
            chk({tag, " stall_req"}, {31'd0, dmem_req_o}, 32'd0);
        end
        dmem_ack_i   = 1'b0;
        WB_MEM_get_i = 1'b1;
        @(posedge clk);
        #1;
        WB_MEM_get_i = 1'b0;
        @(negedge clk);
        chk({tag, " after_give"}, {31'd0, MEM_WB_give_o}, 32'd0);
        chk({tag, " after_mis"}, {31'd0, misaligned_o}, 32'd0);
        chk({tag, " after_get_o"}, {31'd0, MEM_EX_get_o}, 32'd1);
    endtask

    vec_t dir_tbl[8];
    vec_t rv;

    initial begin
        // {instr, result, rs2, rdata, ack_wait, get_wait, req, we, be, wdata, res, mis}
        dir_tbl[0] = '{32'h0000_2023, 32'h100, 32'hDEADBEEF, 32'h0, 2, 0, 1'b1, 1'b1, 4'hF, 32'hDEADBEEF, 32'h100, 1'b0};
        dir_tbl[1] = '{32'h0000_0003, 32'h103, 32'h0, 32'h80AABBCC, 0, 0, 1'b1, 1'b0, 4'hF, 32'h0, 32'hFFFFFF80, 1'b0};
        dir_tbl[2] = '{32'h0000_4003, 32'h103, 32'h0, 32'h80AABBCC, 1, 0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h00000080, 1'b0};
        dir_tbl[3] = '{32'h0000_5003, 32'h102, 32'h0, 32'h80AABBCC, 0, 1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h000080AA, 1'b0};
        dir_tbl[4] = '{32'h0000_1023, 32'h102, 32'h1234ABCD, 32'h0, 0, 0, 1'b1, 1'b1, 4'hC, 32'hABCDABCD, 32'h102, 1'b0};
        dir_tbl[5] = '{32'h0000_0023, 32'h101, 32'h1234ABCD, 32'h0, 1, 0, 1'b1, 1'b1, 4'h2, 32'hCDCDCDCD, 32'h101, 1'b0};
        dir_tbl[6] = '{32'h0000_2003, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h101, 1'b1};
        dir_tbl[7] = '{32'h0000_0033, 32'h55, 32'h0, 32'h0, 0, 4, 1'b0, 1'b0, 4'hF, 32'h0, 32'h55, 1'b0};

        rst_i                = 1'b1;
        EX_MEM_give_i        = 1'b1;
        EX_MEM_instruction_i = 32'h0000_0033;
        EX_MEM_result_i      = 32'hCAFE0000;
        EX_MEM_rs2_i         = 32'h0;
        dmem_ack_i           = 1'b0;
        dmem_rdata_i         = 32'h0;
        WB_MEM_get_i         = 1'b0;

        // Reset held with EX offering: nothing accepted, all outputs low.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst get_o", {31'd0, MEM_EX_get_o}, 32'd0);
            chk("rst req", {31'd0, dmem_req_o}, 32'd0);
            chk("rst give", {31'd0, MEM_WB_give_o}, 32'd0);
            chk("rst result", MEM_WB_result_o, 32'd0);
            chk("rst instr", MEM_WB_instruction_o, 32'd0);
            chk("rst be", {28'd0, dmem_be_o}, 32'd0);
            chk("rst mis", {31'd0, misaligned_o}, 32'd0);
        end
        rst_i         = 1'b0;
        EX_MEM_give_i = 1'b0;
        @(negedge clk);
        chk("post_rst get_o", {31'd0, MEM_EX_get_o}, 32'd1);
        chk("post_rst result", MEM_WB_result_o, 32'd0);

        for (int i = 0; i < 8; i++)
            run_vec(dir_tbl[i], $sformatf("dir%0d", i));

        for (int i = 0; i < 60; i++) begin
            rv.instr = $urandom();
            case ($urandom_range(0, 3))
                0: rv.instr[6:0] = 7'b0000011;
                1: rv.instr[6:0] = 7'b0100011;
                2: rv.instr[6:0] = 7'b0110011;
                default: ;
            endcase
            rv.result = $urandom();
            if ($urandom_range(0, 1) == 0) rv.result[1:0] = 2'b00;
            rv.rs2      = $urandom();
            rv.rdata    = $urandom();
            rv.ack_wait = $urandom_range(0, 3);
            rv.get_wait = $urandom_range(0, 2);
            model(rv);
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        // Reset during an outstanding load; a late ack must be ignored.
        @(negedge clk);
        EX_MEM_give_i        = 1'b1;
        EX_MEM_instruction_i = 32'h0000_2003;
        EX_MEM_result_i      = 32'h200;
        @(posedge clk);
        #1;
        EX_MEM_give_i = 1'b0;
        @(negedge clk);
        chk("midrst req_before", {31'd0, dmem_req_o}, 32'd1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i        = 1'b0;
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h12345678;
        @(negedge clk);
        chk("midrst req_after", {31'd0, dmem_req_o}, 32'd0);
        chk("midrst give_after", {31'd0, MEM_WB_give_o}, 32'd0);
        chk("midrst get_o", {31'd0, MEM_EX_get_o}, 32'd1);
        @(posedge clk);
        #1;
        dmem_ack_i = 1'b0;
        @(negedge clk);
        chk("midrst late_ack_give", {31'd0, MEM_WB_give_o}, 32'd0);
        chk("midrst result_dropped", MEM_WB_result_o, 32'd0);

        run_vec(dir_tbl[7], "recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
